// File: rtl/hm2_arb_pkg.sv
`default_nettype none
// ============================================================================
// hm2_arb_pkg : shared widths and state type for the HostMot2 bus arbiter
// Revision    : 1.0
// ============================================================================
package hm2_arb_pkg;
  localparam int BoardBusWidth  = 32;
  localparam int BoardAddrWidth = 16;
  localparam int NumMasters     = 2;
  localparam int CntWidth       = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RWAIT = 2'd2,
    RESP  = 2'd3
  } arb_state_t;
endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// rr_arb2  : two-way round-robin grant; on a tie the master not granted last wins
// Revision : 1.0
// ============================================================================
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic last_q;
  logic last_d;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_q ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
    // Any grant, contended or not, becomes the new reference for fairness.
    last_d = last_q;
    if (gnt != 2'b00) last_d = gnt[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end
endmodule
`default_nettype wire

// File: rtl/hm2_bus_arbiter.sv
`default_nettype none
// ============================================================================
// hm2_bus_arbiter : shares the HostMot2 register bus between two Avalon-MM masters
// Revision        : 1.0
// ============================================================================
module hm2_bus_arbiter
  import hm2_arb_pkg::*;
#(
  parameter int BusWidth    = BoardBusWidth,
  parameter int AddrWidth   = BoardAddrWidth,
  parameter int ReadLatency = 2
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NumMasters*AddrWidth-1:0] m_addr,
  input  logic [NumMasters-1:0]           m_read,
  input  logic [NumMasters-1:0]           m_write,
  input  logic [NumMasters*BusWidth-1:0]  m_wdata,
  output logic [NumMasters-1:0]           m_waitrequest,
  output logic [NumMasters*BusWidth-1:0]  m_rdata,
  output logic [NumMasters-1:0]           m_rdatavalid,
  output logic [AddrWidth-1:0]            hm2_addr,
  output logic                            hm2_read,
  output logic                            hm2_write,
  output logic [BusWidth-1:0]             hm2_wdata,
  input  logic [BusWidth-1:0]             hm2_rdata,
  output logic [NumMasters-1:0]           proto_err
);
  localparam logic [CntWidth-1:0] LatLoad = CntWidth'(ReadLatency - 1);

  logic [NumMasters-1:0] cmd;
  logic [NumMasters-1:0] accept;

  arb_state_t                   state_q,    state_d;
  logic [AddrWidth-1:0]         addr_q,     addr_d;
  logic [BusWidth-1:0]          wdata_q,    wdata_d;
  logic                         write_op_q, write_op_d;
  logic                         owner_q,    owner_d;
  logic [CntWidth-1:0]          cnt_q,      cnt_d;
  logic                         read_q,     read_d;
  logic                         write_q,    write_d;
  logic [NumMasters*BusWidth-1:0] rdata_q,  rdata_d;
  logic [NumMasters-1:0]        rdvalid_q,  rdvalid_d;
  logic [NumMasters-1:0]        perr_q,     perr_d;

  assign cmd = m_read | m_write;

  rr_arb2 u_rr (
    .clk   (clk),
    .rst_n (reset_n),
    .en    (state_q == IDLE),
    .req   (cmd),
    .gnt   (accept)
  );

  assign m_waitrequest = cmd & ~accept;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    write_op_d = write_op_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    read_d     = 1'b0;
    write_d    = 1'b0;
    rdata_d    = rdata_q;
    rdvalid_d  = '0;
    // Read+write together is served as a write and flagged permanently.
    perr_d     = perr_q | (accept & m_read & m_write);
    case (state_q)
      IDLE: begin
        if (accept != '0) begin
          owner_d    = accept[1];
          addr_d     = accept[1] ? m_addr[2*AddrWidth-1:AddrWidth] : m_addr[AddrWidth-1:0];
          wdata_d    = accept[1] ? m_wdata[2*BusWidth-1:BusWidth]  : m_wdata[BusWidth-1:0];
          write_op_d = accept[1] ? m_write[1] : m_write[0];
          write_d    = write_op_d;
          read_d     = ~write_op_d;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (write_op_q) begin
          state_d = IDLE;
        end else begin
          cnt_d   = LatLoad;
          state_d = (ReadLatency == 1) ? RESP : RWAIT;
        end
      end
      RWAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == 1) state_d = RESP;
      end
      RESP: begin
        if (owner_q) rdata_d[2*BusWidth-1:BusWidth] = hm2_rdata;
        else         rdata_d[BusWidth-1:0]          = hm2_rdata;
        rdvalid_d[owner_q] = 1'b1;
        state_d            = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      write_op_q <= 1'b0;
      owner_q    <= 1'b0;
      cnt_q      <= '0;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      rdata_q    <= '0;
      rdvalid_q  <= '0;
      perr_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      write_op_q <= write_op_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      read_q     <= read_d;
      write_q    <= write_d;
      rdata_q    <= rdata_d;
      rdvalid_q  <= rdvalid_d;
      perr_q     <= perr_d;
    end
  end

  assign hm2_addr     = addr_q;
  assign hm2_wdata    = wdata_q;
  assign hm2_read     = read_q;
  assign hm2_write    = write_q;
  assign m_rdata      = rdata_q;
  assign m_rdatavalid = rdvalid_q;
  assign proto_err    = perr_q;
endmodule
`default_nettype wire
